adder_stage: RTL and testbench

Registered handshake stage that wraps the 6-bit combinational prefix adder `adder` into a streaming pipeline element. Operand pairs enter through a valid/ready port and queue in a small operand FIFO. The FIFO head drives the adder's bit-level x/y inputs, and sum plus carry-out are captured in an output register with a valid/ready port. The block also keeps a sticky overflow flag and a saturating overflow counter for status readout.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder.sv | 56 +++++
 rtl/op_fifo.sv | 50 +++++
 rtl/adder_stage.sv | 88 ++++++++
 tb/tb_adder_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types for the adder pipeline stage: operand width, FIFO entry,
// adder result and the output-register state.
package adder_pkg;

  localparam int WIDTH = 6;

  typedef logic [WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t x;
    operand_t y;
  } op_pair_t;

  typedef struct packed {
    operand_t sum;
    logic     ov;
  } result_t;

  typedef enum logic {
    EMPTY,
    FULL
  } out_state_t;

endpackage

// File: rtl/adder.sv
// 6-bit combinational Kogge-Stone prefix adder with per-bit ports and carry-out.
module adder (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  input  logic y4,
  input  logic y5,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic ov
);

  logic [5:0] x;
  logic [5:0] y;
  logic [5:0] g0;
  logic [5:0] p0;
  logic [5:0] g1;
  logic [5:2] p1;
  logic [5:0] g2;
  logic [5:4] p2;
  logic [5:0] g3;
  logic [5:0] sum;

  assign x  = {x5, x4, x3, x2, x1, x0};
  assign y  = {y5, y4, y3, y2, y1, y0};
  assign g0 = x & y;
  assign p0 = x ^ y;

  // Each level doubles the span; only the propagate bits a later level reads are kept.
  always_comb begin
    g1 = g0;
    for (int i = 1; i < 6; i++) g1[i] = g0[i] | (p0[i] & g0[i-1]);
    for (int i = 2; i < 6; i++) p1[i] = p0[i] & p0[i-1];
    g2 = g1;
    for (int i = 2; i < 6; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
    for (int i = 4; i < 6; i++) p2[i] = p1[i] & p1[i-2];
    g3 = g2;
    for (int i = 4; i < 6; i++) g3[i] = g2[i] | (p2[i] & g2[i-4]);
  end

  assign sum = p0 ^ {g3[4:0], 1'b0};
  assign {s5, s4, s3, s2, s1, s0} = sum;
  assign ov = g3[5];

endmodule

// File: rtl/op_fifo.sv
// Operand FIFO for adder_stage: DEPTH entries (power of two), pointers wrap
// naturally, and a separate occupancy count distinguishes full from empty.
module op_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  op_pair_t push_data,
  input  logic     pop,
  output op_pair_t head,
  output logic     empty,
  output logic     full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  op_pair_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/adder_stage.sv
// Streaming wrapper around the prefix adder: operand FIFO in front, a
// registered result with valid/ready behind it, plus overflow status.
module adder_stage
  import adder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_x,
  input  logic [5:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_sum,
  output logic             out_ov,
  output logic             ov_sticky,
  output logic [CNT_W-1:0] ov_count,
  input  logic             stat_clr
);

  op_pair_t   head;
  op_pair_t   push_data;
  result_t    res;
  out_state_t state;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       load;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign push_data = '{x: in_x, y: in_y};
  assign load      = !fifo_empty && (state == EMPTY || out_ready);
  assign out_valid = (state == FULL);

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (load),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  adder u_adder (
    .x0 (head.x[0]), .x1 (head.x[1]), .x2 (head.x[2]),
    .x3 (head.x[3]), .x4 (head.x[4]), .x5 (head.x[5]),
    .y0 (head.y[0]), .y1 (head.y[1]), .y2 (head.y[2]),
    .y3 (head.y[3]), .y4 (head.y[4]), .y5 (head.y[5]),
    .s0 (res.sum[0]), .s1 (res.sum[1]), .s2 (res.sum[2]),
    .s3 (res.sum[3]), .s4 (res.sum[4]), .s5 (res.sum[5]),
    .ov (res.ov)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      out_sum <= '0;
      out_ov  <= 1'b0;
    end else if (load) begin
      state   <= FULL;
      out_sum <= res.sum;
      out_ov  <= res.ov;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

  // A clear coinciding with an overflow load still records that one overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_sticky <= 1'b0;
      ov_count  <= '0;
    end else if (stat_clr) begin
      ov_sticky <= load && res.ov;
      ov_count  <= CNT_W'(load && res.ov);
    end else if (load && res.ov) begin
      ov_sticky <= 1'b1;
      if (ov_count != '1) ov_count <= ov_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_stage.sv
// Self-checking bench for adder_stage: a queue-based reference model of the
// stage is compared against the DUT every cycle, plus directed literal checks.
module tb_adder_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_x;
  logic [5:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_sum;
  logic             out_ov;
  logic             ov_sticky;
  logic [CNT_W-1:0] ov_count;
  logic             stat_clr;

  adder_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ov    (out_ov),
    .ov_sticky (ov_sticky),
    .ov_count  (ov_count),
    .stat_clr  (stat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int sum;
    int ov;
    int acc;
  } exp_t;

  typedef struct {
    int sum;
    int ov;
    int cyc;
  } res_t;

  exp_t q[$];
  res_t rlog[$];
  bit   shown    = 0;
  bit   m_sticky = 0;
  int   m_cnt    = 0;
  int   cyc      = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Model: every accepted pair is queued with its accept cycle; the oldest
  // pair becomes the visible result one edge after it was accepted at the earliest.
  always @(posedge clk or posedge rst) begin
    bit   exp_ready;
    bit   ld;
    int   ldov;
    exp_t e;
    res_t r;
    if (rst) begin
      q.delete();
      shown    = 0;
      m_sticky = 0;
      m_cnt    = 0;
    end else begin
      cyc++;
      exp_ready = (q.size() - int'(shown)) < DEPTH;
      if (shown && out_ready) begin
        r.sum = q[0].sum; r.ov = q[0].ov; r.cyc = cyc;
        rlog.push_back(r);
        void'(q.pop_front());
        shown = 0;
      end
      if (in_valid && exp_ready) begin
        e.x = int'(in_x); e.y = int'(in_y);
        e.sum = (e.x + e.y) % 64;
        e.ov  = (e.x + e.y) > 63 ? 1 : 0;
        e.acc = cyc;
        q.push_back(e);
      end
      ld = 0;
      if (q.size() > 0 && !shown && q[0].acc < cyc) begin
        shown = 1;
        ld = 1;
      end
      ldov = ld ? q[0].ov : 0;
      if (stat_clr) begin
        m_sticky = (ldov != 0);
        m_cnt    = ldov;
      end else if (ldov != 0) begin
        m_sticky = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("out_valid", int'(out_valid), int'(shown));
      checkOutput("in_ready", int'(in_ready), ((q.size() - int'(shown)) < DEPTH) ? 1 : 0);
      if (shown) begin
        checkOutput("out_sum", int'(out_sum), q[0].sum);
        checkOutput("out_ov", int'(out_ov), q[0].ov);
      end
      checkOutput("ov_sticky", int'(ov_sticky), int'(m_sticky));
      checkOutput("ov_count", int'(ov_count), m_cnt);
    end
  end

  // Presents one pair and returns just after the edge that accepted it.
  task automatic applyStimulus(input int x, input int y);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = 6'(x);
    in_y = 6'(y);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (n >= 100) checkOutput("push_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int ok;
    int n;
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    out_ready = 1'b0; stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_sum", int'(out_sum), 0);
    checkOutput("rst_out_ov", int'(out_ov), 0);
    checkOutput("rst_sticky", int'(ov_sticky), 0);
    checkOutput("rst_count", int'(ov_count), 0);
    rst = 1'b0;

    $display("[TB] basic add and latency");
    out_ready = 1'b1;
    applyStimulus(5, 3);
    idle();
    checkOutput("lat_not_yet", int'(out_valid), 0);
    @(negedge clk);
    checkOutput("lat_valid", int'(out_valid), 1);
    checkOutput("sum_5_3", int'(out_sum), 8);
    checkOutput("ov_5_3", int'(out_ov), 0);
    checkOutput("cnt_5_3", int'(ov_count), 0);

    $display("[TB] overflow results");
    applyStimulus(63, 1);
    applyStimulus(32, 32);
    idle();
    repeat (3) @(negedge clk);
    checkOutput("log_size_ov", rlog.size(), 3);
    checkOutput("log_63_1_sum", rlog[1].sum, 0);
    checkOutput("log_63_1_ov", rlog[1].ov, 1);
    checkOutput("log_32_32_sum", rlog[2].sum, 0);
    checkOutput("log_32_32_ov", rlog[2].ov, 1);
    checkOutput("sticky_after_ov", int'(ov_sticky), 1);
    checkOutput("count_after_ov", int'(ov_count), 2);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(1, 1);
    applyStimulus(2, 2);
    applyStimulus(3, 3);
    @(negedge clk);
    checkOutput("bp_in_ready_low", int'(in_ready), 0);
    in_valid = 1'b1; in_x = 6'd4; in_y = 6'd4;
    repeat (3) @(negedge clk);
    checkOutput("bp_stalled", int'(in_ready), 0);
    checkOutput("bp_held", q.size(), 3);
    base = rlog.size();
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (n >= 100) checkOutput("bp_timeout", 0, 1);
    idle();
    repeat (4) @(negedge clk);
    checkOutput("bp_count", rlog.size() - base, 4);
    for (int i = 0; i < 4; i++)
      checkOutput("bp_order", rlog[base + i].sum, 2 * (i + 1));

    $display("[TB] streaming");
    base = rlog.size();
    for (int i = 0; i < 64; i++) applyStimulus(i, 63 - i);
    idle();
    repeat (4) @(negedge clk);
    checkOutput("stream_count", rlog.size() - base, 64);
    ok = 1;
    for (int i = base; i < rlog.size(); i++)
      if (rlog[i].sum != 63 || rlog[i].ov != 0) ok = 0;
    checkOutput("stream_values", ok, 1);
    if (rlog.size() - base == 64)
      checkOutput("stream_no_bubble", rlog[base + 63].cyc - rlog[base].cyc, 63);

    $display("[TB] saturation and clear");
    for (int i = 0; i < 300; i++) applyStimulus(63, 63);
    idle();
    repeat (4) @(negedge clk);
    checkOutput("sat_count", int'(ov_count), 255);
    checkOutput("sat_model", m_cnt, 255);
    applyStimulus(63, 63);
    @(negedge clk);
    in_valid = 1'b0;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checkOutput("clr_load_count", int'(ov_count), 1);
    checkOutput("clr_load_sticky", int'(ov_sticky), 1);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checkOutput("clr_count", int'(ov_count), 0);
    checkOutput("clr_sticky", int'(ov_sticky), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = 6'($urandom_range(0, 63));
      in_y      = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 3) != 0);
      stat_clr  = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] asynchronous reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(10, 20);
    applyStimulus(11, 21);
    applyStimulus(12, 22);
    idle();
    checkOutput("pre_rst_valid", int'(out_valid), 1);
    checkOutput("pre_rst_ready", int'(in_ready), 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", int'(out_valid), 0);
    checkOutput("async_rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checkOutput("no_stale_result", seen, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
